rs_encoder: RTL

- Systematic RS(255,239) encoder over GF(2^8). Transmit-side counterpart of the decoder's syndrome calculation stage.
- Primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D). Generator g(x) = prod_{i=0..2t-1}(x - alpha^i), so the encoded frame has zero syndromes at alpha^0..alpha^15.
- Accepts k message symbols serially and passes them straight through. Then emits 2t parity symbols from a 16-stage GF LFSR.
- Output symbol order matches the decoder input order: first symbol out is the highest-degree coefficient.

---
 rtl/rs_encoder_pkg.sv | 76 +++++++
 rtl/rs_encoder_if.sv | 32 +++
 rtl/rs_encoder_gf_mul.sv | 21 ++
 rtl/rs_encoder.sv | 139 +++++++++++++
 4 files changed

// File: rtl/rs_encoder_pkg.sv
// Shared constants, types and GF(2^8) helpers for the RS(255,239) encoder.
// Generator coefficients are folded at elaboration from the field definition.
package rs_encoder_pkg;

  localparam int RS_N  = 255;
  localparam int RS_T  = 8;
  localparam int RS_M  = 8;
  localparam int RS_2T = 2 * RS_T;
  localparam int RS_K  = RS_N - RS_2T;  // n = k + 2t holds by construction
  localparam int CNT_W = 8;

  localparam logic [RS_M:0] GF_PRIM_POLY = 9'h11D;

  typedef enum logic [1:0] {
    IDLE,
    MSG,
    PARITY
  } rs_state_t;

  typedef logic [RS_M-1:0]                sym_t;
  typedef logic [RS_2T-1:0][RS_M-1:0]     par_vec_t;
  typedef logic [RS_M-1:0][RS_M-1:0]      mul_mat_t;

  // Multiply by alpha (x) modulo the primitive polynomial.
  function automatic sym_t gf_xtime(input sym_t a);
    return {a[RS_M-2:0], 1'b0} ^ (a[RS_M-1] ? GF_PRIM_POLY[RS_M-1:0] : '0);
  endfunction

  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t p;
    sym_t x;
    p = '0;
    x = a;
    for (int i = 0; i < RS_M; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // g(x) = prod_{i=0..2t-1} (x + alpha^i); returns g_0..g_{2t-1}, g_{2t} = 1 implied.
  function automatic par_vec_t gen_coef();
    logic [RS_2T:0][RS_M-1:0] g;
    sym_t                     root;
    par_vec_t                 res;
    g    = '0;
    g[0] = sym_t'(1);
    root = sym_t'(1);
    for (int i = 0; i < RS_2T; i++) begin
      for (int j = RS_2T; j > 0; j--) begin
        g[j] = g[j-1] ^ gf_mul(g[j], root);
      end
      g[0] = gf_mul(g[0], root);
      root = gf_xtime(root);
    end
    for (int j = 0; j < RS_2T; j++) begin
      res[j] = g[j];
    end
    return res;
  endfunction

  // Column j is c * alpha^j: the product is the XOR of columns selected by input bits.
  function automatic mul_mat_t const_mul_matrix(input sym_t c);
    mul_mat_t m;
    sym_t     x;
    x = c;
    for (int j = 0; j < RS_M; j++) begin
      m[j] = x;
      x    = gf_xtime(x);
    end
    return m;
  endfunction

  localparam par_vec_t RS_GEN_COEF = gen_coef();

endpackage

// File: rtl/rs_encoder_if.sv
// Symbol stream interface: message symbols in, codeword symbols out.
interface rs_encoder_if;

  logic [rs_encoder_pkg::RS_M-1:0] data_in;
  logic                            in_valid;
  logic                            in_ready;
  logic [rs_encoder_pkg::RS_M-1:0] data_out;
  logic                            out_valid;
  logic                            out_sof;
  logic                            out_eof;

  modport master (
    output data_in,
    output in_valid,
    input  in_ready,
    input  data_out,
    input  out_valid,
    input  out_sof,
    input  out_eof
  );

  modport slave (
    input  data_in,
    input  in_valid,
    output in_ready,
    output data_out,
    output out_valid,
    output out_sof,
    output out_eof
  );

endinterface

// File: rtl/rs_encoder_gf_mul.sv
// Multiply a GF(2^8) symbol by a fixed constant using a pure XOR network.
module rs_encoder_gf_mul
  import rs_encoder_pkg::*;
#(
  parameter sym_t COEF = '0
) (
  input  sym_t a,
  output sym_t p
);

  localparam mul_mat_t COLS = const_mul_matrix(COEF);

  // NOTE: p is given a value before the loop so every path assigns it and no latch is inferred.
  always_comb begin
    p = '0;
    for (int j = 0; j < RS_M; j++) begin
      if (a[j]) p = p ^ COLS[j];
    end
  end

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(255,239) encoder: message symbols pass through, then 16 parity
// symbols shift out of the division LFSR, highest-degree coefficient first.
module rs_encoder
  import rs_encoder_pkg::*;
(
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         sync,
  rs_encoder_if.slave  bus
);

  rs_state_t        state_q, state_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0] par_cnt_q, par_cnt_d;
  par_vec_t         par_q, par_d;
  par_vec_t         par_base;
  par_vec_t         prod;
  par_vec_t         lfsr_next;
  sym_t             fb;
  sym_t             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             accept;

  assign bus.in_ready  = !rst_in && !sync && (state_q != PARITY);
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.data_out  = dout_q;
  assign bus.out_valid = valid_q;
  assign bus.out_sof   = sof_q;
  assign bus.out_eof   = eof_q;

  // A new frame always divides from an all-zero remainder.
  assign par_base = (state_q == IDLE) ? '0 : par_q;
  assign fb       = bus.data_in ^ par_base[RS_2T-1];

  for (genvar i = 0; i < RS_2T; i++) begin : g_mul
    rs_encoder_gf_mul #(
      .COEF (RS_GEN_COEF[i])
    ) u_mul (
      .a (fb),
      .p (prod[i])
    );
  end

  always_comb begin
    lfsr_next = prod;
    for (int i = 1; i < RS_2T; i++) begin
      lfsr_next[i] = par_base[i-1] ^ prod[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    par_cnt_d = par_cnt_q;
    par_d     = par_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;

    if (sync) begin
      state_d   = IDLE;
      sym_cnt_d = '0;
      par_cnt_d = '0;
      par_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d   = MSG;
            sym_cnt_d = CNT_W'(1);
            par_d     = lfsr_next;
            dout_d    = bus.data_in;
            valid_d   = 1'b1;
            sof_d     = 1'b1;
          end
        end

        MSG: begin
          if (accept) begin
            par_d   = lfsr_next;
            dout_d  = bus.data_in;
            valid_d = 1'b1;
            if (sym_cnt_q == CNT_W'(RS_K - 1)) begin
              state_d   = PARITY;
              sym_cnt_d = '0;
              par_cnt_d = '0;
            end else begin
              sym_cnt_d = sym_cnt_q + CNT_W'(1);
            end
          end
        end

        PARITY: begin
          dout_d    = par_q[RS_2T-1];
          valid_d   = 1'b1;
          par_d     = {par_q[RS_2T-2:0], sym_t'(0)};
          par_cnt_d = par_cnt_q + CNT_W'(1);
          if (par_cnt_q == CNT_W'(RS_2T - 1)) begin
            eof_d     = 1'b1;
            state_d   = IDLE;
            par_cnt_d = '0;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // NOTE: <= makes every flop sample pre-edge values, so the LFSR shifts as one register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      sym_cnt_q <= '0;
      par_cnt_q <= '0;
      par_q     <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_cnt_q <= sym_cnt_d;
      par_cnt_q <= par_cnt_d;
      par_q     <= par_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
    end
  end

endmodule
